address_translation_unit: RTL

Multi-channel successor to the single-requester memory management unit: arbitrates linear-address translation requests from `CHANNELS` clients (fetch, data, ...) round-robin. Each request is translated through an optional translation lookaside buffer (TLB) or an external page-table walker. Paging-disabled requests bypass translation. Sits between the segmentation stage and the bus interface unit, after linear address formation.

---
 rtl/mmu_pkg.sv | 13 +
 rtl/translation_lookaside_buffer.sv | 55 +++++
 rtl/address_translation_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types for the address translation unit and its TLB.
package mmu_pkg;
    localparam int PAGE_OFFSET_BITS = 12;

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESPOND} mmu_state_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] tag;
        logic [19:0] frame;
        logic        writable;
    } tlb_entry_t;
endpackage

// File: rtl/translation_lookaside_buffer.sv
// translation_lookaside_buffer: fully associative page cache, FIFO replacement.
// Elaborated only when ADDRESS_TRANSLATION_UNIT_TLB_EN is defined.
// Ports: clock/reset; tag (page number being looked up and filled);
// hit/hit_frame/hit_writable (combinational lookup); flush (clears all
// valid bits, beats fill); fill_en/fill_frame/fill_writable (write at fill_ptr).
`ifdef ADDRESS_TRANSLATION_UNIT_TLB_EN
module translation_lookaside_buffer
    import mmu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] tag,
    output logic        hit,
    output logic [19:0] hit_frame,
    output logic        hit_writable,
    input  logic        flush,
    input  logic        fill_en,
    input  logic [19:0] fill_frame,
    input  logic        fill_writable
);
    localparam int PW = $clog2(DEPTH);

    tlb_entry_t      entries [DEPTH];
    logic [PW-1:0]   fill_ptr;

    always_comb begin
        hit          = 1'b0;
        hit_frame    = '0;
        hit_writable = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (entries[i].valid && entries[i].tag == tag) begin
                hit          = 1'b1;
                hit_frame    = entries[i].frame;
                hit_writable = entries[i].writable;
            end
    end

    // A flush coinciding with a fill wins: the fill is dropped and fill_ptr holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
            fill_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i].valid <= 1'b0;
        end else if (fill_en) begin
            entries[fill_ptr] <= '{valid: 1'b1, tag: tag, frame: fill_frame, writable: fill_writable};
            fill_ptr          <= fill_ptr + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/address_translation_unit.sv
// address_translation_unit: round-robin multi-channel linear-to-physical translation.
// Ports: clock/reset; per-channel i_vaild/i_linear_address/i_write_enable;
// i_paging_enable, i_tlb_flush; per-channel o_ready/o_fault pulses with shared
// o_physical_address; walker handshake o_walk_vaild/o_walk_linear_address and
// i_walk_ready/i_walk_physical_address/i_walk_writable/i_walk_fault.
// Macro ADDRESS_TRANSLATION_UNIT_TLB_EN adds the TLB; without it every paged
// request walks.
module address_translation_unit
    import mmu_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int TLB_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   i_vaild,
    input  logic [CHANNELS*32-1:0] i_linear_address,
    input  logic [CHANNELS-1:0]   i_write_enable,
    input  logic                  i_paging_enable,
    input  logic                  i_tlb_flush,
    output logic [CHANNELS-1:0]   o_ready,
    output logic [CHANNELS-1:0]   o_fault,
    output logic [31:0]           o_physical_address,
    output logic                  o_walk_vaild,
    output logic [31:0]           o_walk_linear_address,
    input  logic                  i_walk_ready,
    input  logic [31:0]           i_walk_physical_address,
    input  logic                  i_walk_writable,
    input  logic                  i_walk_fault
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    mmu_state_t      state, next_state;
    logic [CH_W-1:0] rr_ptr, grant, req_idx;
    logic            req_found;
    logic [31:0]     lat_addr, result;
    logic            lat_write, fault_q;
    logic            tlb_hit, hit_writable, fill_en;
    logic [19:0]     hit_frame;
    logic            unused_bits;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        logic [CH_W-1:0] c;
        c         = '0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            c = CH_W'((int'(rr_ptr) + k) % CHANNELS);
            if (i_vaild[c]) begin
                req_found = 1'b1;
                req_idx   = c;
            end
        end
    end

`ifdef ADDRESS_TRANSLATION_UNIT_TLB_EN
    logic raw_hit;

    translation_lookaside_buffer #(.DEPTH(TLB_DEPTH)) u_tlb (
        .clock         (clock),
        .reset         (reset),
        .tag           (lat_addr[31:PAGE_OFFSET_BITS]),
        .hit           (raw_hit),
        .hit_frame     (hit_frame),
        .hit_writable  (hit_writable),
        .flush         (i_tlb_flush),
        .fill_en       (fill_en),
        .fill_frame    (i_walk_physical_address[31:PAGE_OFFSET_BITS]),
        .fill_writable (i_walk_writable)
    );

    // A flush arriving during lookup must not let a stale entry hit.
    assign tlb_hit     = raw_hit & ~i_tlb_flush;
    assign unused_bits = ^{i_walk_physical_address[PAGE_OFFSET_BITS-1:0]};
`else
    assign tlb_hit      = 1'b0;
    assign hit_frame    = '0;
    assign hit_writable = 1'b0;
    assign unused_bits  = ^{i_tlb_flush, i_walk_physical_address[PAGE_OFFSET_BITS-1:0], TLB_DEPTH[0]};
`endif

    always_comb begin
        next_state   = state;
        o_ready      = '0;
        o_fault      = '0;
        o_walk_vaild = 1'b0;
        fill_en      = 1'b0;
        case (state)
            IDLE:    next_state = req_found ? LOOKUP : IDLE;
            LOOKUP:  next_state = (!i_paging_enable || tlb_hit) ? RESPOND : WALK;
            WALK: begin
                o_walk_vaild = 1'b1;
                fill_en      = i_walk_ready & ~i_walk_fault;
                next_state   = i_walk_ready ? RESPOND : WALK;
            end
            RESPOND: begin
                o_ready[grant] = 1'b1;
                o_fault[grant] = fault_q;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant     <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            result    <= '0;
            fault_q   <= 1'b0;
        end else if (state == IDLE && req_found) begin
            grant     <= req_idx;
            rr_ptr    <= CH_W'((int'(req_idx) + 1) % CHANNELS);
            lat_addr  <= i_linear_address[int'(req_idx)*32 +: 32];
            lat_write <= i_write_enable[req_idx];
        end else if (state == LOOKUP && !i_paging_enable) begin
            result    <= lat_addr;
            fault_q   <= 1'b0;
        end else if (state == LOOKUP && tlb_hit) begin
            result    <= {hit_frame, lat_addr[PAGE_OFFSET_BITS-1:0]};
            fault_q   <= lat_write & ~hit_writable;
        end else if (state == WALK && i_walk_ready) begin
            result    <= i_walk_fault ? '0 : {i_walk_physical_address[31:PAGE_OFFSET_BITS], lat_addr[PAGE_OFFSET_BITS-1:0]};
            fault_q   <= i_walk_fault | (lat_write & ~i_walk_writable);
        end
    end

    assign o_physical_address    = result;
    assign o_walk_linear_address = lat_addr;
endmodule
